// File: rtl/bcd_display_scanner_pkg.sv
// bcd_display_scanner_pkg: scan-state encoding and active-low display constants
package bcd_display_scanner_pkg;
  localparam logic [1:0] SCAN_D0 = 2'd0;
  localparam logic [1:0] SCAN_D1 = 2'd1;
  localparam logic [1:0] SCAN_D2 = 2'd2;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
endpackage

// File: rtl/bcd_display_scanner_sevenseg.sv
// bcd_to_sevenseg: 4-bit nibble to active-low {g,f,e,d,c,b,a} segment decoder
module bcd_to_sevenseg
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bin2bcd.sv
// bin2bcd: combinational 8-bit binary to 3-digit BCD (double dabble)
module bin2bcd (
  input  logic [7:0]  bin,
  output logic [11:0] bcd
);
  logic [19:0] s;
  always_comb begin
    s = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      s[11:8] = s[11:8] > 4'd4 ? s[11:8] + 4'd3 : s[11:8];
      s[15:12] = s[15:12] > 4'd4 ? s[15:12] + 4'd3 : s[15:12];
      s = s << 1;
    end
  end
  assign bcd = s[19:8];
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: load a byte, convert to BCD and scan it onto a 3-digit active-low display
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [7:0]  value_in,
  input  logic        blank_en,
  output logic        upd_done,
  output logic [11:0] bcd_out,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [7:0] value_q, value_d;
  logic pend_q, pend_d, upd_q, upd_d;
  logic [11:0] bcd_q, bcd_d, bcd_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic [3:0] an_q, an_d, nib;
  logic [6:0] seg_q, seg_d, seg_w;
  logic tc, blank, off;
  bin2bcd u_bin2bcd (.bin(value_q), .bcd(bcd_w));
  bcd_to_sevenseg u_sevenseg (.nib(nib), .seg(seg_w));
  always_comb begin
    value_d = load ? value_in : value_q;
    pend_d = load;
    bcd_d = pend_q ? bcd_w : bcd_q;
    upd_d = pend_q;
    tc = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d = !en ? cnt_q : tc ? '0 : cnt_q + 1'b1;
    state_d = (!en || !tc) ? state_q : state_q == SCAN_D2 ? SCAN_D0 : state_q + 2'd1;
    nib = state_q == SCAN_D0 ? bcd_q[3:0] : state_q == SCAN_D1 ? bcd_q[7:4] : bcd_q[11:8];
    blank = blank_en && (state_q == SCAN_D2 ? bcd_q[11:8] == 4'd0 :
                         state_q == SCAN_D1 ? bcd_q[11:4] == 8'd0 : 1'b0);
    off = !en || blank;
    an_d = off ? AN_OFF : state_q == SCAN_D0 ? 4'b1110 : state_q == SCAN_D1 ? 4'b1101 : 4'b1011;
    seg_d = off ? SEG_OFF : seg_w;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      pend_q <= 1'b0;
      upd_q <= 1'b0;
      bcd_q <= '0;
      cnt_q <= '0;
      state_q <= SCAN_D0;
      an_q <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      value_q <= value_d;
      pend_q <= pend_d;
      upd_q <= upd_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign upd_done = upd_q;
  assign bcd_out = bcd_q;
  assign an = an_q;
  assign seg = seg_q;
  assign dp = 1'b1;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0, blank_en = 1'b0;
  logic [7:0] value_in = 8'd0;
  logic upd_done, dp;
  logic [11:0] bcd_out;
  logic [3:0] an;
  logic [6:0] seg;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  bcd_display_scanner #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .value_in(value_in),
    .blank_en(blank_en), .upd_done(upd_done), .bcd_out(bcd_out), .an(an),
    .seg(seg), .dp(dp)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  initial begin
    int lit, c0, c1, c2;
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_upd", 32'(upd_done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h000);
    chk("rst_dp", 32'(dp), 32'd1);
    reset = 1'b0; en = 1'b1; load = 1'b1; value_in = 8'd255;
    tick();
    chk("ld255_upd_e1", 32'(upd_done), 32'd0);
    load = 1'b0;
    tick();
    chk("ld255_upd_e2", 32'(upd_done), 32'd1);
    chk("ld255_bcd", 32'(bcd_out), 32'h255);
    tick();
    chk("ld255_upd_e3", 32'(upd_done), 32'd0);
    chk("d0_an", 32'(an), 32'b1110);
    chk("d0_seg", 32'(seg), 32'b0010010);
    tick(2);
    chk("d1_an", 32'(an), 32'b1101);
    chk("d1_seg", 32'(seg), 32'b0010010);
    tick(3);
    chk("d1_last_an", 32'(an), 32'b1101);
    tick();
    chk("d2_an", 32'(an), 32'b1011);
    chk("d2_seg", 32'(seg), 32'b0100100);
    tick(4);
    chk("wrap_an", 32'(an), 32'b1110);
    blank_en = 1'b1; load = 1'b1; value_in = 8'd7;
    tick();
    load = 1'b0;
    tick(2);
    lit = 0;
    for (int i = 0; i < 12; i++) begin
      chk("blk7_an3", 32'(an[3]), 32'd1);
      if (an == 4'b1110) begin
        lit++;
        chk("blk7_seg", 32'(seg), 32'b1111000);
      end else begin
        chk("blk7_an_off", 32'(an), 32'hF);
        chk("blk7_seg_off", 32'(seg), 32'h7F);
      end
      tick();
    end
    chk("blk7_lit", 32'(lit), 32'd4);
    load = 1'b1; value_in = 8'd100;
    tick();
    load = 1'b0;
    tick(2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 12; i++) begin
      if (an == 4'b1110) begin
        c0++;
        chk("b100_ones", 32'(seg), 32'b1000000);
      end else if (an == 4'b1101) begin
        c1++;
        chk("b100_tens", 32'(seg), 32'b1000000);
      end else if (an == 4'b1011) begin
        c2++;
        chk("b100_hund", 32'(seg), 32'b1111001);
      end else
        chk("b100_an", 32'(an), 32'b1110);
      tick();
    end
    chk("b100_c0", 32'(c0), 32'd4);
    chk("b100_c1", 32'(c1), 32'd4);
    chk("b100_c2", 32'(c2), 32'd4);
    load = 1'b1; value_in = 8'd12;
    tick();
    value_in = 8'd200;
    chk("b2b_upd0", 32'(upd_done), 32'd0);
    tick();
    load = 1'b0;
    chk("b2b_upd1", 32'(upd_done), 32'd1);
    chk("b2b_bcd1", 32'(bcd_out), 32'h012);
    tick();
    chk("b2b_upd2", 32'(upd_done), 32'd1);
    chk("b2b_bcd2", 32'(bcd_out), 32'h200);
    tick();
    chk("b2b_upd3", 32'(upd_done), 32'd0);
    tick(6);
    chk("en_pre_an", 32'(an), 32'b1101);
    en = 1'b0;
    tick();
    chk("en_off_an", 32'(an), 32'hF);
    chk("en_off_seg", 32'(seg), 32'h7F);
    tick(5);
    chk("en_hold_an", 32'(an), 32'hF);
    en = 1'b1;
    tick();
    chk("en_resume_an", 32'(an), 32'b1101);
    chk("en_resume_seg", 32'(seg), 32'b1000000);
    tick(2);
    chk("en_rem_an", 32'(an), 32'b1101);
    tick();
    chk("en_next_an", 32'(an), 32'b1011);
    chk("en_next_seg", 32'(seg), 32'b0100100);
    load = 1'b1; value_in = 8'd9;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_upd", 32'(upd_done), 32'd0);
    chk("mid_rst_bcd", 32'(bcd_out), 32'h000);
    load = 1'b0;
    tick();
    reset = 1'b0; blank_en = 1'b0;
    tick();
    chk("post_rst_an", 32'(an), 32'b1110);
    chk("post_rst_seg", 32'(seg), 32'b1000000);
    chk("post_rst_upd", 32'(upd_done), 32'd0);
    chk("post_rst_bcd", 32'(bcd_out), 32'h000);
    tick(3);
    chk("post_rst_d0_end", 32'(an), 32'b1110);
    tick();
    chk("post_rst_d1", 32'(an), 32'b1101);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
